// File: rtl/sdram_cmd_arbiter_if.sv
// Request-FIFO read ports and the command handshake toward the SDRAM controller core.
// The arbiter drives through the master modport; the FIFOs and the core sit on the slave side.
interface sdram_cmd_arbiter_if #(
  parameter int unsigned AddrWidth = 24,
  parameter int unsigned DataWidth = 16
);

  logic                           i_wq_empty;
  logic                           o_wq_rd_en;
  logic [AddrWidth+DataWidth-1:0] i_wq_data;

  logic                           i_rq_empty;
  logic                           o_rq_rd_en;
  logic [AddrWidth-1:0]           i_rq_addr;

  logic                           o_cmd_valid;
  logic                           i_cmd_ready;
  logic [1:0]                     o_cmd_op;
  logic [AddrWidth-1:0]           o_cmd_addr;
  logic [DataWidth-1:0]           o_cmd_wdata;

  logic                           o_ref_overrun;

  modport master (
    input  i_wq_empty, i_wq_data, i_rq_empty, i_rq_addr, i_cmd_ready,
    output o_wq_rd_en, o_rq_rd_en, o_cmd_valid, o_cmd_op, o_cmd_addr, o_cmd_wdata,
           o_ref_overrun
  );

  modport slave (
    output i_wq_empty, i_wq_data, i_rq_empty, i_rq_addr, i_cmd_ready,
    input  o_wq_rd_en, o_rq_rd_en, o_cmd_valid, o_cmd_op, o_cmd_addr, o_cmd_wdata,
           o_ref_overrun
  );

endinterface

// File: rtl/sdram_cmd_arbiter.sv
// Schedules refresh, read and write commands from two request FIFOs onto a single
// valid/ready command port, with a starvation guard that bounds read streaks.
module sdram_cmd_arbiter #(
  parameter int unsigned AddrWidth       = 24,
  parameter int unsigned DataWidth       = 16,
  parameter int unsigned RefreshInterval = 780,
  parameter int unsigned StarveLimit     = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  sdram_cmd_arbiter_if.master bus
);

  localparam int unsigned RefW  = $clog2(RefreshInterval);
  localparam int unsigned StrkW = $clog2(StarveLimit + 1);

  localparam logic [RefW-1:0]  RefReload = RefW'(RefreshInterval - 1);
  localparam logic [StrkW-1:0] StrkMax   = StrkW'(StarveLimit);

  localparam logic [1:0] OpRead    = 2'b01;
  localparam logic [1:0] OpWrite   = 2'b10;
  localparam logic [1:0] OpRefresh = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    LATCH = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t            state;
  logic [RefW-1:0]   ref_cnt;
  logic              ref_pending;
  logic [StrkW-1:0]  streak;
  logic              sel_write;

  logic              ref_expire_c;
  logic              cmd_hs_c;
  logic              ref_hs_c;
  logic              grant_ref_c;
  logic              grant_wr_c;
  logic              grant_rd_c;

  assign ref_expire_c = (ref_cnt == '0);
  assign cmd_hs_c     = (state == ISSUE) && bus.o_cmd_valid && bus.i_cmd_ready;
  assign ref_hs_c     = cmd_hs_c && (bus.o_cmd_op == OpRefresh);

  // IDLE grant: refresh first, then reads, unless writes have waited out a full streak
  always_comb begin
    grant_ref_c = 1'b0;
    grant_wr_c  = 1'b0;
    grant_rd_c  = 1'b0;
    if (state == IDLE) begin
      if (ref_pending) begin
        grant_ref_c = 1'b1;
      end else if (!bus.i_wq_empty && (streak == StrkMax)) begin
        grant_wr_c = 1'b1;
      end else if (!bus.i_rq_empty) begin
        grant_rd_c = 1'b1;
      end else if (!bus.i_wq_empty) begin
        grant_wr_c = 1'b1;
      end
    end
  end

  // Free-running refresh timer; a second expiry before the first refresh is taken is sticky
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ref_cnt           <= RefReload;
      ref_pending       <= 1'b0;
      bus.o_ref_overrun <= 1'b0;
    end else begin
      ref_cnt <= ref_expire_c ? RefReload : ref_cnt - RefW'(1);
      if (ref_expire_c) begin
        ref_pending <= 1'b1;
      end else if (ref_hs_c) begin
        ref_pending <= 1'b0;
      end
      if (ref_expire_c && ref_pending && !ref_hs_c) begin
        bus.o_ref_overrun <= 1'b1;
      end
    end
  end

  // Consecutive read grants while writes wait
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      streak <= '0;
    end else if (bus.i_wq_empty || grant_wr_c) begin
      streak <= '0;
    end else if (grant_rd_c && (streak != StrkMax)) begin
      streak <= streak + StrkW'(1);
    end
  end

  // Command FSM with registered FIFO strobes and command outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= IDLE;
      sel_write       <= 1'b0;
      bus.o_wq_rd_en  <= 1'b0;
      bus.o_rq_rd_en  <= 1'b0;
      bus.o_cmd_valid <= 1'b0;
      bus.o_cmd_op    <= 2'b00;
      bus.o_cmd_addr  <= '0;
      bus.o_cmd_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ref_c) begin
            bus.o_cmd_valid <= 1'b1;
            bus.o_cmd_op    <= OpRefresh;
            bus.o_cmd_addr  <= '0;
            bus.o_cmd_wdata <= '0;
            state           <= ISSUE;
          end else if (grant_wr_c) begin
            sel_write      <= 1'b1;
            bus.o_wq_rd_en <= 1'b1;
            state          <= POP;
          end else if (grant_rd_c) begin
            sel_write      <= 1'b0;
            bus.o_rq_rd_en <= 1'b1;
            state          <= POP;
          end
        end
        POP: begin
          bus.o_wq_rd_en <= 1'b0;
          bus.o_rq_rd_en <= 1'b0;
          state          <= LATCH;
        end
        LATCH: begin
          if (sel_write) begin
            bus.o_cmd_op    <= OpWrite;
            bus.o_cmd_addr  <= bus.i_wq_data[DataWidth +: AddrWidth];
            bus.o_cmd_wdata <= bus.i_wq_data[0 +: DataWidth];
          end else begin
            bus.o_cmd_op    <= OpRead;
            bus.o_cmd_addr  <= bus.i_rq_addr;
            bus.o_cmd_wdata <= '0;
          end
          bus.o_cmd_valid <= 1'b1;
          state           <= ISSUE;
        end
        ISSUE: begin
          if (bus.i_cmd_ready) begin
            bus.o_cmd_valid <= 1'b0;
            bus.o_cmd_op    <= 2'b00;
            bus.o_cmd_addr  <= '0;
            bus.o_cmd_wdata <= '0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter: FIFO models on both request ports, a handshake
// monitor, and hand-computed expectations for refresh timing, ordering, stalls and reset.
module tb_sdram_cmd_arbiter;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;

  logic clk;
  logic rst;

  sdram_cmd_arbiter_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

  sdram_cmd_arbiter #(
    .AddrWidth      (AW),
    .DataWidth      (DW),
    .RefreshInterval(16),
    .StarveLimit    (4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Request FIFO models: ring buffers filled by the stimulus, popped on the strobe edge
  logic [AW+DW-1:0] wq_mem [16];
  logic [AW-1:0]    rq_mem [16];
  int wq_wr = 0;
  int wq_rd = 0;
  int rq_wr = 0;
  int rq_rd = 0;
  int wq_pops = 0;
  int rq_pops = 0;
  int bad_pops = 0;
  int both_pops = 0;
  int cyc = 0;

  assign bus.i_wq_empty = (wq_wr == wq_rd);
  assign bus.i_rq_empty = (rq_wr == rq_rd);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_wq_rd_en && bus.o_rq_rd_en) both_pops <= both_pops + 1;
    if (bus.o_wq_rd_en) begin
      wq_pops <= wq_pops + 1;
      if (wq_wr == wq_rd) bad_pops <= bad_pops + 1;
      else begin
        bus.i_wq_data <= wq_mem[wq_rd % 16];
        wq_rd <= wq_rd + 1;
      end
    end
    if (bus.o_rq_rd_en) begin
      rq_pops <= rq_pops + 1;
      if (rq_wr == rq_rd) bad_pops <= bad_pops + 1;
      else begin
        bus.i_rq_addr <= rq_mem[rq_rd % 16];
        rq_rd <= rq_rd + 1;
      end
    end
  end

  // Accepted-command monitor
  logic [1:0]    mon_op   [$];
  logic [AW-1:0] mon_addr [$];
  logic [DW-1:0] mon_wd   [$];
  int            mon_cyc  [$];

  always @(posedge clk) begin
    if (!rst && bus.o_cmd_valid && bus.i_cmd_ready) begin
      mon_op.push_back(bus.o_cmd_op);
      mon_addr.push_back(bus.o_cmd_addr);
      mon_wd.push_back(bus.o_cmd_wdata);
      mon_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wq_mem[wq_wr % 16] = {a, d};
    wq_wr++;
  endtask

  task automatic push_rd(input logic [AW-1:0] a);
    rq_mem[rq_wr % 16] = a;
    rq_wr++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Called just after reset release with ready low: the first refresh lands on cycle 17
  task automatic check_first_refresh(input string tag);
    int early;
    early = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (bus.o_cmd_valid !== 1'b0) early++;
    end
    chk({tag, "_quiet"}, 64'(early), 64'h0);
    tick();
    chk({tag, "_valid"}, 64'(bus.o_cmd_valid), 64'h1);
    chk({tag, "_op"},    64'(bus.o_cmd_op),    64'h3);
    chk({tag, "_addr"},  64'(bus.o_cmd_addr),  64'h0);
    chk({tag, "_wdata"}, 64'(bus.o_cmd_wdata), 64'h0);
  endtask

  initial begin
    logic [1:0] exp_op [11];
    int base, n_rw, rk, wk, j, unstable;
    int rw_cyc [2];

    rst = 1'b1;
    bus.i_cmd_ready = 1'b0;
    exp_op = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    rw_cyc = '{0, 0};

    // Reset state and first refresh with both FIFOs empty
    tick();
    tick();
    chk("rst_valid",   64'(bus.o_cmd_valid),   64'h0);
    chk("rst_op",      64'(bus.o_cmd_op),      64'h0);
    chk("rst_rd_en",   64'({bus.o_wq_rd_en, bus.o_rq_rd_en}), 64'h0);
    chk("rst_overrun", 64'(bus.o_ref_overrun), 64'h0);
    rst = 1'b0;
    check_first_refresh("ref0");
    bus.i_cmd_ready = 1'b1;
    tick();
    chk("ref0_done", 64'(bus.o_cmd_valid), 64'h0);
    chk("ref0_no_pops", 64'(wq_pops + rq_pops), 64'h0);

    // Single write
    do_reset();
    push_wr(24'h001234, 16'hBEEF);
    tick();
    chk("wr_pop",     64'({bus.o_wq_rd_en, bus.o_rq_rd_en}), 64'h2);
    chk("wr_valid_t1", 64'(bus.o_cmd_valid), 64'h0);
    tick();
    chk("wr_pop_end", 64'({bus.o_wq_rd_en, bus.o_rq_rd_en}), 64'h0);
    tick();
    chk("wr_valid", 64'(bus.o_cmd_valid), 64'h1);
    chk("wr_op",    64'(bus.o_cmd_op),    64'h2);
    chk("wr_addr",  64'(bus.o_cmd_addr),  64'h001234);
    chk("wr_wdata", 64'(bus.o_cmd_wdata), 64'hBEEF);
    tick();
    chk("wr_done", 64'(bus.o_cmd_valid), 64'h0);
    for (int k = 0; k < 4; k++) tick();
    chk("wr_one_pop", 64'(wq_pops), 64'h1);

    // 8 reads + 3 writes: starvation guard ordering, refreshes filtered out
    do_reset();
    base = mon_op.size();
    for (int k = 0; k < 8; k++) push_rd(24'h000100 + 24'(k));
    for (int k = 0; k < 3; k++) push_wr(24'h000200 + 24'(k), 16'hA000 + 16'(k));
    n_rw = 0;
    for (int c = 0; c < 200 && n_rw < 11; c++) begin
      tick();
      n_rw = 0;
      for (int i = base; i < mon_op.size(); i++) if (mon_op[i] != 2'b11) n_rw++;
    end
    chk("seq_count", 64'(n_rw), 64'd11);
    rk = 0;
    wk = 0;
    j = 0;
    for (int i = base; i < mon_op.size() && j < 11; i++) begin
      if (mon_op[i] == 2'b11) continue;
      chk($sformatf("seq_op%0d", j), 64'(mon_op[i]), 64'(exp_op[j]));
      if (exp_op[j] == 2'b01) begin
        chk($sformatf("seq_raddr%0d", rk), 64'(mon_addr[i]), 64'(24'h000100 + 24'(rk)));
        chk($sformatf("seq_rwd%0d", rk),   64'(mon_wd[i]),   64'h0);
        rk++;
      end else begin
        chk($sformatf("seq_waddr%0d", wk), 64'(mon_addr[i]), 64'(24'h000200 + 24'(wk)));
        chk($sformatf("seq_wwd%0d", wk),   64'(mon_wd[i]),   64'(16'hA000 + 16'(wk)));
        wk++;
      end
      if (j < 2) rw_cyc[j] = mon_cyc[i];
      j++;
    end
    chk("seq_gap", 64'(rw_cyc[1] - rw_cyc[0]), 64'd4);
    chk("seq_pops", 64'({wq_pops[15:0], rq_pops[15:0]}), 64'h0004_0008);

    // Back-pressure during a read, refresh pending meanwhile wins the next IDLE
    do_reset();
    bus.i_cmd_ready = 1'b0;
    push_rd(24'h00ABCD);
    push_rd(24'h001111);
    tick();
    tick();
    tick();
    chk("stall_valid", 64'(bus.o_cmd_valid), 64'h1);
    chk("stall_op",    64'(bus.o_cmd_op),    64'h1);
    chk("stall_addr",  64'(bus.o_cmd_addr),  64'h00ABCD);
    unstable = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.o_cmd_valid !== 1'b1 || bus.o_cmd_op !== 2'b01 || bus.o_cmd_addr !== 24'h00ABCD)
        unstable++;
    end
    chk("stall_stable", 64'(unstable), 64'h0);
    chk("stall_no_pop", 64'(rq_pops), 64'd9);
    bus.i_cmd_ready = 1'b1;
    tick();
    chk("stall_accept", 64'(bus.o_cmd_valid), 64'h0);
    chk("stall_mon_addr", 64'(mon_addr[mon_addr.size() - 1]), 64'h00ABCD);
    tick();
    chk("stall_ref_next", 64'({bus.o_cmd_valid, bus.o_cmd_op}), 64'h7);
    for (int k = 0; k < 8; k++) tick();
    chk("stall_drain", 64'(rq_pops), 64'd10);
    chk("stall_no_overrun", 64'(bus.o_ref_overrun), 64'h0);

    // Refresh expiry during LATCH of a read, then overrun under sustained back-pressure
    do_reset();
    for (int k = 0; k < 13; k++) tick();
    push_rd(24'h00CAFE);
    tick();
    chk("latch_pop", 64'(bus.o_rq_rd_en), 64'h1);
    tick();
    tick();
    chk("latch_read_first", 64'({bus.o_cmd_valid, bus.o_cmd_op}), 64'h5);
    chk("latch_read_addr",  64'(bus.o_cmd_addr), 64'h00CAFE);
    tick();
    chk("latch_read_done", 64'(bus.o_cmd_valid), 64'h0);
    tick();
    chk("latch_ref_next", 64'({bus.o_cmd_valid, bus.o_cmd_op}), 64'h7);
    bus.i_cmd_ready = 1'b0;
    for (int k = 0; k < 13; k++) tick();
    chk("ovr_before", 64'(bus.o_ref_overrun), 64'h0);
    tick();
    chk("ovr_set", 64'(bus.o_ref_overrun), 64'h1);
    for (int k = 0; k < 20; k++) tick();
    chk("ovr_sticky", 64'(bus.o_ref_overrun), 64'h1);
    chk("ovr_ref_held", 64'({bus.o_cmd_valid, bus.o_cmd_op}), 64'h7);

    // Reset while in ISSUE
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(bus.o_cmd_valid), 64'h0);
    chk("mid_rst_cmd",   64'({bus.o_cmd_op, bus.o_cmd_addr, bus.o_cmd_wdata}), 64'h0);
    chk("mid_rst_rd_en", 64'({bus.o_wq_rd_en, bus.o_rq_rd_en}), 64'h0);
    chk("mid_rst_overrun", 64'(bus.o_ref_overrun), 64'h0);
    rst = 1'b0;
    check_first_refresh("ref1");
    bus.i_cmd_ready = 1'b1;
    tick();

    chk("no_empty_pops", 64'(bad_pops), 64'h0);
    chk("no_dual_pops",  64'(both_pops), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_arbiter.md
# sdram_cmd_arbiter

Single-clock scheduler between the request FIFOs and the SDRAM controller core. Pops write requests (address + data) and read requests (address) from two FIFO read ports, generates periodic auto-refresh requests, and presents one command at a time to the core over a valid/ready handshake. Sits in the controller clock domain, on the read side of both request FIFOs.

## Interface
- AddrWidth, 24, SDRAM word address width
- DataWidth, 16, write data width
- RefreshInterval, 780, cycles between refresh requests (≥ 8)
- StarveLimit, 4, max consecutive read grants while writes are waiting (≥ 1)

- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_wq_empty  in  1  write-request FIFO empty
- o_wq_rd_en  out  1  write-request FIFO pop strobe
- i_wq_data  in  AddrWidth+DataWidth  popped entry; {addr, data}, addr in upper bits; valid the cycle after the pop strobe
- i_rq_empty  in  1  read-request FIFO empty
- o_rq_rd_en  out  1  read-request FIFO pop strobe
- i_rq_addr  in  AddrWidth  popped read address; valid the cycle after the pop strobe
- o_cmd_valid  out  1  command available to core
- i_cmd_ready  in  1  core accepts command
- o_cmd_op  out  2  01 read, 10 write, 11 refresh (00 never issued while valid)
- o_cmd_addr  out  AddrWidth  command address (0 for refresh)
- o_cmd_wdata  out  DataWidth  write data (0 for read/refresh)
- o_ref_overrun  out  1  sticky: refresh interval expired while a refresh was still pending

## Operation
- States: IDLE, POP, LATCH, ISSUE. All outputs registered.
- Reset: state IDLE; every output 0; refresh counter loaded to RefreshInterval-1; refresh_pending 0; read streak counter 0.
- Refresh timer: decrements every cycle; at 0 sets refresh_pending and reloads RefreshInterval-1. Expiry while refresh_pending already 1 sets o_ref_overrun (cleared only by reset). refresh_pending clears on the refresh command handshake.
- IDLE grant priority: refresh_pending > read (i_rq_empty=0) > write (i_wq_empty=0). Exception: if write queue non-empty and streak == StarveLimit, grant write over read.
- Streak: +1 on each read grant, cleared on write grant or whenever i_wq_empty=1; saturates at StarveLimit.
- Refresh grant: IDLE -> ISSUE with op=11, addr=0, wdata=0.
- Read/write grant: IDLE -> POP; selected rd_en high exactly during POP. POP -> LATCH. In LATCH capture i_rq_addr or i_wq_data into command registers. LATCH -> ISSUE.
- ISSUE: o_cmd_valid=1; op/addr/wdata held stable until i_cmd_ready=1 at a rising edge; then -> IDLE with o_cmd_valid=0.
- Nothing granted in IDLE -> stay in IDLE.
- Exactly one pop per command; both rd_en strobes never high together; never pop a FIFO whose empty flag was 1 in the granting IDLE cycle.
- Refresh becoming pending during POP/LATCH/ISSUE does not abort the in-flight command; it wins the next IDLE cycle.
- Reset mid-operation: returns to IDLE next edge; an entry already popped is dropped (upstream re-issues); o_cmd_valid falls the cycle after i_rst.

## Timing
- Read/write: grant in IDLE at cycle T -> rd_en high T+1 -> data captured T+2 -> o_cmd_valid high T+3.
- Refresh: grant at T -> o_cmd_valid high T+1.
- With i_cmd_ready held 1: one read/write every 4 cycles; one refresh every 2 cycles.
- Handshake completes on the edge where o_cmd_valid & i_cmd_ready; back-pressure stalls indefinitely in ISSUE, timer keeps running.

## Test plan
- Reset then idle, both FIFOs empty, RefreshInterval=16: o_cmd_valid stays 0 for 15 cycles; first refresh (op 11, addr 0) valid at cycle 17 after reset release; no rd_en pulses.
- Single write {addr 24'h00_1234, data 16'hBEEF}, ready=1: exactly one o_wq_rd_en pulse; o_cmd_valid 3 cycles after grant with op 10, addr 001234, wdata BEEF.
- 8 reads and 3 writes queued, StarveLimit=4, ready=1: op sequence R,R,R,R,W,R,R,R,R,W,W (all data matching FIFO order).
- Hold i_cmd_ready=0 for 20 cycles during a read: op/addr stable, valid held, no further pops; accepted on first ready cycle.
- Refresh expiry during a LATCH of a read: read issues first, refresh issues next; with ready=0 across 2×RefreshInterval, o_ref_overrun goes 1 and stays 1.
- Assert i_rst while in ISSUE: next cycle all outputs 0, state IDLE, refresh counter restarted, o_ref_overrun cleared.
